// File: rtl/kbd_pkg.sv
// Shared scan-code constants and state/direction types for the keyboard player arbiter.
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DN    = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_t;

    typedef enum logic {DIR_UP, DIR_DN} dir_t;

endpackage

// File: rtl/kbd_player_arbiter_if.sv
// Scan-code input, player-2 source selection and per-player control outputs.
interface kbd_player_arbiter_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       kbd_p2;
    logic       btnU;
    logic       btnD;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic       serve;

    modport master (
        output rx_data, rx_valid, kbd_p2, btnU, btnD,
        input  p1_up, p1_down, p2_up, p2_down, serve
    );

    modport slave (
        input  rx_data, rx_valid, kbd_p2, btnU, btnD,
        output p1_up, p1_down, p2_up, p2_down, serve
    );

endinterface

// File: rtl/kbd_player_arbiter_dir_resolver.sv
// Tracks up/down held flags and the most recent press for one player; up and down
// are mutually exclusive, with the latest press winning while both are held.
module dir_resolver
    import kbd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic press_up,
    input  logic press_dn,
    input  logic rel_up,
    input  logic rel_dn,
    output logic up,
    output logic down
);

    logic up_held;
    logic dn_held;
    logic up_held_nxt;
    logic dn_held_nxt;
    dir_t last;
    dir_t last_nxt;

    // Outputs are resolved from next-state flags so they move on the same edge as the event.
    always_comb begin
        up_held_nxt = press_up | (up_held & ~rel_up);
        dn_held_nxt = press_dn | (dn_held & ~rel_dn);
        last_nxt    = last;
        if (press_dn) last_nxt = DIR_DN;
        if (press_up) last_nxt = DIR_UP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_held <= 1'b0;
            dn_held <= 1'b0;
            last    <= DIR_UP;
            up      <= 1'b0;
            down    <= 1'b0;
        end else begin
            up_held <= up_held_nxt;
            dn_held <= dn_held_nxt;
            last    <= last_nxt;
            up      <= up_held_nxt & (~dn_held_nxt | (last_nxt == DIR_UP));
            down    <= dn_held_nxt & (~up_held_nxt | (last_nxt == DIR_DN));
        end
    end

endmodule

// File: rtl/kbd_player_arbiter.sv
// Decodes PS/2 make/break sequences into paddle directions for two players and a
// one-shot serve pulse; player 2 may be driven by buttons instead of the arrows.
module kbd_player_arbiter
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65000,
    parameter int TO_W        = 17
) (
    input logic                  clk,
    input logic                  rst,
    kbd_player_arbiter_if.slave  kbd
);

    kbd_state_t      state;
    logic [TO_W-1:0] to_cnt;
    logic            is_prefix;
    logic            ext;
    logic            make_ev;
    logic            brk_ev;
    logic            key_w;
    logic            key_s;
    logic            key_up;
    logic            key_dn;
    logic            key_space;
    logic            space_held;
    logic            serve_r;
    logic            btnU_q;
    logic            btnD_q;
    logic            p1_up_r;
    logic            p1_down_r;
    logic            kp2_up;
    logic            kp2_down;
    logic            bp2_up;
    logic            bp2_down;

    // A non-prefix byte completes a make from IDLE/EXT or a break from BRK/EXT_BRK.
    always_comb begin
        is_prefix = (kbd.rx_data == SC_EXT) | (kbd.rx_data == SC_BRK);
        ext       = (state == EXT) | (state == EXT_BRK);
        make_ev   = kbd.rx_valid & ~is_prefix & ((state == IDLE) | (state == EXT));
        brk_ev    = kbd.rx_valid & ~is_prefix & ((state == BRK) | (state == EXT_BRK));
        key_w     = (kbd.rx_data == SC_W)     & ~ext;
        key_s     = (kbd.rx_data == SC_S)     & ~ext;
        key_up    = (kbd.rx_data == SC_UP)    &  ext;
        key_dn    = (kbd.rx_data == SC_DN)    &  ext;
        key_space = (kbd.rx_data == SC_SPACE) & ~ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else if (kbd.rx_valid) begin
            to_cnt <= '0;
            case (state)
                IDLE: begin
                    if (kbd.rx_data == SC_EXT)      state <= EXT;
                    else if (kbd.rx_data == SC_BRK) state <= BRK;
                    else                            state <= IDLE;
                end
                EXT: begin
                    if (kbd.rx_data == SC_BRK)      state <= EXT_BRK;
                    else if (kbd.rx_data == SC_EXT) state <= EXT;
                    else                            state <= IDLE;
                end
                BRK:     state <= IDLE;
                EXT_BRK: state <= IDLE;
            endcase
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt == TO_W'(TIMEOUT_CYC)) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Serve fires only on the first make of Space; typematic repeats are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            serve_r    <= 1'b0;
            space_held <= 1'b0;
            btnU_q     <= 1'b0;
            btnD_q     <= 1'b0;
        end else begin
            serve_r <= make_ev & key_space & ~space_held;
            if (make_ev & key_space)     space_held <= 1'b1;
            else if (brk_ev & key_space) space_held <= 1'b0;
            btnU_q <= kbd.btnU;
            btnD_q <= kbd.btnD;
        end
    end

    dir_resolver u_p1 (
        .clk      (clk),
        .rst      (rst),
        .press_up (make_ev & key_w),
        .press_dn (make_ev & key_s),
        .rel_up   (brk_ev & key_w),
        .rel_dn   (brk_ev & key_s),
        .up       (p1_up_r),
        .down     (p1_down_r)
    );

    dir_resolver u_p2_kbd (
        .clk      (clk),
        .rst      (rst),
        .press_up (make_ev & key_up),
        .press_dn (make_ev & key_dn),
        .rel_up   (brk_ev & key_up),
        .rel_dn   (brk_ev & key_dn),
        .up       (kp2_up),
        .down     (kp2_down)
    );

    dir_resolver u_p2_btn (
        .clk      (clk),
        .rst      (rst),
        .press_up (kbd.btnU & ~btnU_q),
        .press_dn (kbd.btnD & ~btnD_q),
        .rel_up   (~kbd.btnU & btnU_q),
        .rel_dn   (~kbd.btnD & btnD_q),
        .up       (bp2_up),
        .down     (bp2_down)
    );

    assign kbd.p1_up   = p1_up_r;
    assign kbd.p1_down = p1_down_r;
    assign kbd.p2_up   = kbd.kbd_p2 ? kp2_up   : bp2_up;
    assign kbd.p2_down = kbd.kbd_p2 ? kp2_down : bp2_down;
    assign kbd.serve   = serve_r;

endmodule

// File: tb/tb_kbd_player_arbiter.sv
// Directed scan-code and button sequences checked against a per-cycle behavioural model.
module tb_kbd_player_arbiter;

    localparam int T = 50;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   serve_cnt = 0;
    bit   check_en = 1'b0;

    kbd_player_arbiter_if bus();

    kbd_player_arbiter #(.TIMEOUT_CYC(T), .TO_W(17)) dut (
        .clk (clk),
        .rst (rst),
        .kbd (bus)
    );

    always #5 clk = ~clk;

    bit   m_w, m_s, m_u, m_d, m_space, m_pbu, m_pbd;
    bit   pf_ext, pf_brk;
    int   last1, last2, lastb;
    int   gap;
    bit   e_p1u, e_p1d, e_kp2u, e_kp2d, e_bp2u, e_bp2d, e_serve;

    task automatic keyEvent(input logic [7:0] b, input bit ext, input bit make);
        if (b == 8'h1D && !ext) begin m_w = make; if (make) last1 = 0; end
        if (b == 8'h1B && !ext) begin m_s = make; if (make) last1 = 1; end
        if (b == 8'h75 &&  ext) begin m_u = make; if (make) last2 = 0; end
        if (b == 8'h72 &&  ext) begin m_d = make; if (make) last2 = 1; end
        if (b == 8'h29 && !ext) begin
            if (make && !m_space) e_serve = 1'b1;
            m_space = make;
        end
    endtask

    // Model: a prefix survives at most T idle cycles; most recent press wins per player.
    always @(posedge clk) begin
        logic [7:0] b;
        bit ru, rd;
        if (rst) begin
            {m_w, m_s, m_u, m_d, m_space, m_pbu, m_pbd, pf_ext, pf_brk} = '0;
            last1 = 0; last2 = 0; lastb = 0; gap = 0;
            {e_p1u, e_p1d, e_kp2u, e_kp2d, e_bp2u, e_bp2d, e_serve} = '0;
        end else begin
            e_serve = 1'b0;
            if (bus.rx_valid) begin
                b = bus.rx_data;
                if (gap > T) begin pf_ext = 0; pf_brk = 0; end
                gap = 0;
                if (pf_brk) begin
                    if (b != 8'hE0 && b != 8'hF0) keyEvent(b, pf_ext, 1'b0);
                    pf_ext = 0; pf_brk = 0;
                end else if (b == 8'hF0) pf_brk = 1;
                else if (b == 8'hE0) pf_ext = 1;
                else begin
                    keyEvent(b, pf_ext, 1'b1);
                    pf_ext = 0;
                end
            end else begin
                gap++;
            end
            ru = bus.btnU && !m_pbu;
            rd = bus.btnD && !m_pbd;
            if (rd) lastb = 1;
            if (ru) lastb = 0;
            m_pbu = bus.btnU;
            m_pbd = bus.btnD;
            e_p1u  = m_w & (!m_s | last1 == 0);
            e_p1d  = m_s & (!m_w | last1 == 1);
            e_kp2u = m_u & (!m_d | last2 == 0);
            e_kp2d = m_d & (!m_u | last2 == 1);
            e_bp2u = bus.btnU & (!bus.btnD | lastb == 0);
            e_bp2d = bus.btnD & (!bus.btnU | lastb == 1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model p1_up",   32'(bus.p1_up),   32'(e_p1u));
            checkOutput("model p1_down", 32'(bus.p1_down), 32'(e_p1d));
            checkOutput("model p2_up",   32'(bus.p2_up),   32'(bus.kbd_p2 ? e_kp2u : e_bp2u));
            checkOutput("model p2_down", 32'(bus.p2_down), 32'(bus.kbd_p2 ? e_kp2d : e_bp2d));
            checkOutput("model serve",   32'(bus.serve),   32'(e_serve));
            if (bus.serve === 1'b1) serve_cnt++;
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic setButtons(input logic u, input logic d);
        bus.btnU = u;
        bus.btnD = d;
        @(negedge clk); #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " p1_up"},   32'(bus.p1_up),   0);
        checkOutput({tag, " p1_down"}, 32'(bus.p1_down), 0);
        checkOutput({tag, " p2_up"},   32'(bus.p2_up),   0);
        checkOutput({tag, " p2_down"}, 32'(bus.p2_down), 0);
        checkOutput({tag, " serve"},   32'(bus.serve),   0);
    endtask

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
        bus.kbd_p2 = 1'b1; bus.btnU = 1'b0; bus.btnD = 1'b0;
        idle(3);
        check_en = 1'b1;
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] player 1 keys and keypad-8 rejection");
        applyStimulus(8'h1D);
        checkOutput("p1_up after W", 32'(bus.p1_up), 1);
        applyStimulus(8'h75);
        checkOutput("p2_up keypad8", 32'(bus.p2_up), 0);
        applyStimulus(8'h1B);
        checkOutput("p1_down S wins", 32'(bus.p1_down), 1);
        checkOutput("p1_up S wins", 32'(bus.p1_up), 0);
        applyStimulus(8'hF0); applyStimulus(8'h1B);
        checkOutput("p1_up after S release", 32'(bus.p1_up), 1);
        applyStimulus(8'hF0); applyStimulus(8'h1D);
        checkOutput("p1_up after W release", 32'(bus.p1_up), 0);

        $display("[TB] player 2 arrows");
        applyStimulus(8'hE0); applyStimulus(8'h75);
        checkOutput("p2_up arrow", 32'(bus.p2_up), 1);
        applyStimulus(8'hE0); applyStimulus(8'h72);
        checkOutput("p2_down latest", 32'(bus.p2_down), 1);
        checkOutput("p2_up latest", 32'(bus.p2_up), 0);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h72);
        checkOutput("p2_up after down break", 32'(bus.p2_up), 1);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        checkOutput("p2_up released", 32'(bus.p2_up), 0);
        applyStimulus(8'hE0); applyStimulus(8'hE0); applyStimulus(8'h72);
        checkOutput("p2_down double E0", 32'(bus.p2_down), 1);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h72);

        $display("[TB] serve pulses");
        applyStimulus(8'h29);
        checkOutput("serve first", 32'(bus.serve), 1);
        applyStimulus(8'h29);
        checkOutput("serve repeat", 32'(bus.serve), 0);
        applyStimulus(8'h29);
        applyStimulus(8'hF0); applyStimulus(8'h29);
        applyStimulus(8'h29);
        checkOutput("serve second", 32'(bus.serve), 1);
        idle(2);
        checkOutput("serve count", 32'(serve_cnt), 2);
        applyStimulus(8'hF0); applyStimulus(8'h29);

        $display("[TB] prefix timeout");
        applyStimulus(8'hE0); idle(20); applyStimulus(8'h75);
        checkOutput("p2_up short gap", 32'(bus.p2_up), 1);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        applyStimulus(8'hE0); idle(60); applyStimulus(8'h72);
        checkOutput("p2_down after timeout", 32'(bus.p2_down), 0);
        applyStimulus(8'hF0); idle(60); applyStimulus(8'h1D);
        checkOutput("p1_up break timed out", 32'(bus.p1_up), 1);
        applyStimulus(8'hF0); applyStimulus(8'h1D);

        $display("[TB] button mode");
        bus.kbd_p2 = 1'b0;
        setButtons(1'b1, 1'b0);
        checkOutput("btn p2_up", 32'(bus.p2_up), 1);
        setButtons(1'b1, 1'b1);
        checkOutput("btn p2_down", 32'(bus.p2_down), 1);
        checkOutput("btn p2_up both", 32'(bus.p2_up), 0);
        applyStimulus(8'hE0); applyStimulus(8'h75);
        checkOutput("btn ignores kbd", 32'(bus.p2_down), 1);
        setButtons(1'b0, 1'b0);
        checkOutput("btn released", 32'(bus.p2_down), 0);
        bus.kbd_p2 = 1'b1;
        idle(1);
        checkOutput("switch to kbd", 32'(bus.p2_up), 1);
        bus.kbd_p2 = 1'b0;
        setButtons(1'b1, 1'b1);
        checkOutput("btn same-cycle up", 32'(bus.p2_up), 1);
        checkOutput("btn same-cycle down", 32'(bus.p2_down), 0);
        setButtons(1'b0, 1'b0);
        bus.kbd_p2 = 1'b1;
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);

        $display("[TB] reset mid-sequence");
        applyStimulus(8'h1D);
        applyStimulus(8'hE0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkAllZero("mid reset");
        applyStimulus(8'h72);
        checkOutput("p2_down after reset", 32'(bus.p2_down), 0);
        applyStimulus(8'h1D);
        checkOutput("p1_up after reset", 32'(bus.p1_up), 1);
        idle(3);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
